fir_cff_bank: RTL and testbench
===============================

Name: fir_cff_bank

Overview:
- Coefficient responder for the CORE_FIR coefficient port, i.e. the memory end that CORE_FIR reads through cff_ptr/cff_out.
- Replaces a fixed coefficient ROM with double-buffered RAM. The filter reads the active bank with 1-cycle latency while a host streams a new coefficient set into the shadow bank.
- The banks swap only while the filter is not sequencing, so a frame never uses mixed coefficient sets.
- One instance per band filter.

Parameters:
- ADDR_W, 10, width of cff_ptr.
- DATA_W, 16, coefficient width (signed).
- NUM_TAPS, 1024, coefficients per set. Must satisfy 1 <= NUM_TAPS <= 2**ADDR_W.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- cff_ptr  in  ADDR_W  coefficient address from CORE_FIR
- cff_out  out  DATA_W  signed coefficient data to CORE_FIR, registered
- sequencing  in  1  high while CORE_FIR is processing a frame
- ld_start  in  1  single-cycle pulse: begin loading a new set
- ld_vld  in  1  ld_data valid
- ld_data  in  DATA_W  coefficient word; the first word goes to address 0
- ld_rdy  out  1  block accepts a word this cycle
- ld_done  out  1  single-cycle pulse: swap completed
- ld_err  out  1  single-cycle pulse: load aborted or restarted
- active_bank  out  1  bank currently served on cff_out
- swap_pend  out  1  complete set loaded, waiting for sequencing low

Behaviour:
- Reset (asynchronous, rst high):
  - cff_out=0, active_bank=0, state=IDLE.
  - ld_rdy, ld_done, ld_err, swap_pend all 0; wr_ptr=0.
  - RAM contents are not reset.
- Read path:
  - Every cycle, cff_out <= bank[active_bank][cff_ptr], giving 1-cycle latency, identical timing to the ROM it replaces.
  - If cff_ptr >= NUM_TAPS, cff_out <= 0.
  - Reads are unaffected by writes, because writes always target bank[~active_bank].
- IDLE:
  - ld_rdy=0.
  - ld_start -> LOAD, wr_ptr=0.
  - ld_vld is ignored.
- LOAD:
  - ld_rdy=1.
  - On ld_vld&ld_rdy: write ld_data to bank[~active_bank][wr_ptr] and increment wr_ptr.
  - If the write is at wr_ptr==NUM_TAPS-1 -> WAIT_SWAP, with ld_rdy=0 from the next cycle.
  - ld_start in LOAD (including the same cycle as a write): pulse ld_err, set wr_ptr=0, stay in LOAD. The concurrent word is discarded.
- WAIT_SWAP:
  - swap_pend=1, ld_rdy=0.
  - In the first cycle with sequencing==0: toggle active_bank, pulse ld_done, -> IDLE.
  - A read issued in the swap cycle returns the old bank; reads from the next cycle onward return the new bank.
  - ld_start in WAIT_SWAP: pulse ld_err, discard the pending set, -> LOAD with wr_ptr=0, no swap.
- Simultaneous events:
  - If sequencing is low on the cycle the final word is written, the swap occurs on the following cycle, not the same cycle.
- Reset mid-load:
  - Discards the partial set and returns active_bank to 0.
  - The coefficients then served are whatever bank 0 holds; the host must reload.
- wr_ptr width is ADDR_W bits and never wraps past NUM_TAPS-1.

Optional Feature:
- Macro: FIR_CFF_CHECKSUM_EN.
- With the macro defined:
  - Extra ports ld_chk (in, DATA_W) and ld_sum (out, DATA_W).
  - ld_sum is a modulo-2**DATA_W sum of all words accepted since the last ld_start. It is cleared by ld_start and by reset.
  - On acceptance of the final word, the final sum (including that word) is compared with ld_chk sampled in the same cycle.
  - Match -> WAIT_SWAP as normal.
  - Mismatch -> pulse ld_err, -> IDLE, no swap, active bank untouched.
- Without the macro: the ports are absent and every complete load proceeds to WAIT_SWAP.

Test Plan:
- Reset, then NUM_TAPS=4. Load 0x0001,0x0002,0x0003,0x7FFF with sequencing=0 -> swap_pend never needed more than 1 cycle; ld_done pulses 1 cycle after the last write. active_bank=1. cff_ptr=3 -> cff_out=0x7FFF one cycle later.
- Load with sequencing=1 held 20 cycles after the last word -> swap_pend=1 throughout, cff_out still old bank. Drop sequencing -> ld_done next cycle, new data on the following read.
- Sweep cff_ptr 0..3 while loading the shadow bank with different values -> cff_out tracks the old set unchanged, 1-cycle latency each.
- ld_start after 2 of 4 words -> ld_err pulse, wr_ptr=0. Reload 4 words -> correct set at addresses 0..3.
- cff_ptr=5 with NUM_TAPS=4 -> cff_out=0.
- FIR_CFF_CHECKSUM_EN: words 0x8000,0x8000,0x0001,0x0002 with ld_chk=0x0003 -> swap. Same words with ld_chk=0x0004 -> ld_err, active_bank unchanged, state IDLE.

Source files
------------

// File: rtl/fir_cff_bank.sv
`default_nettype none
// ============================================================================
// Module  : fir_cff_bank
// Brief   : Double-buffered coefficient RAM behind the CORE_FIR coefficient port.
//           The host streams a new set into the shadow bank. The banks swap
//           while the filter is idle. Optional macro: FIR_CFF_CHECKSUM_EN.
// Rev     : 1.0
// ============================================================================
module fir_cff_bank #(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 16,
    parameter int NUM_TAPS = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] cff_ptr,
    output logic [DATA_W-1:0] cff_out,
    input  logic              sequencing,
    input  logic              ld_start,
    input  logic              ld_vld,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_rdy,
    output logic              ld_done,
    output logic              ld_err,
    output logic              active_bank,
    output logic              swap_pend
`ifdef FIR_CFF_CHECKSUM_EN
    ,
    input  logic [DATA_W-1:0] ld_chk,
    output logic [DATA_W-1:0] ld_sum
`endif
);

    localparam logic [ADDR_W:0]   c_num_taps = (ADDR_W+1)'(NUM_TAPS);
    localparam logic [ADDR_W-1:0] c_last_ptr = ADDR_W'(NUM_TAPS - 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOAD      = 2'd1,
        ST_WAIT_SWAP = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DATA_W-1:0] r_mem [0:(2**(ADDR_W+1))-1];
    logic [DATA_W-1:0] r_cff_out;
    logic              r_active_bank;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic              r_ld_done;
    logic              r_ld_err;
    logic              w_accept;
    logic              w_last;
    logic              w_chk_ok;
    logic              w_swap;
    logic              w_err;

    // A word arriving together with ld_start is dropped: the restart wins.
    assign w_accept = (r_state == ST_LOAD) && ld_vld && !ld_start;
    assign w_last   = w_accept && (r_wr_ptr == c_last_ptr);

`ifdef FIR_CFF_CHECKSUM_EN
    logic [DATA_W-1:0] r_sum;
    logic [DATA_W-1:0] w_sum_nxt;

    assign w_sum_nxt = r_sum + ld_data;
    assign w_chk_ok  = (w_sum_nxt == ld_chk);
    assign ld_sum    = r_sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum <= '0;
        end else if (ld_start) begin
            r_sum <= '0;
        end else if (w_accept) begin
            r_sum <= w_sum_nxt;
        end
    end
`else
    assign w_chk_ok = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_swap      = 1'b0;
        w_err       = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (ld_start) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (ld_start) begin
                    w_err = 1'b1;
                end else if (w_last) begin
                    if (w_chk_ok) begin
                        w_state_nxt = ST_WAIT_SWAP;
                    end else begin
                        w_err       = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            ST_WAIT_SWAP: begin
                if (ld_start) begin
                    w_err       = 1'b1;
                    w_state_nxt = ST_LOAD;
                end else if (!sequencing) begin
                    w_swap      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr      <= '0;
            r_active_bank <= 1'b0;
            r_ld_done     <= 1'b0;
            r_ld_err      <= 1'b0;
        end else begin
            r_ld_done <= w_swap;
            r_ld_err  <= w_err;
            if (w_swap) begin
                r_active_bank <= ~r_active_bank;
            end
            if (ld_start || w_last) begin
                r_wr_ptr <= '0;
            end else if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
        end
    end

    // Storage is not reset; writes only ever target the shadow bank.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[{~r_active_bank, r_wr_ptr}] <= ld_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cff_out <= '0;
        end else if ({1'b0, cff_ptr} < c_num_taps) begin
            r_cff_out <= r_mem[{r_active_bank, cff_ptr}];
        end else begin
            r_cff_out <= '0;
        end
    end

    assign cff_out     = r_cff_out;
    assign active_bank = r_active_bank;
    assign ld_done     = r_ld_done;
    assign ld_err      = r_ld_err;
    assign ld_rdy      = (r_state == ST_LOAD);
    assign swap_pend   = (r_state == ST_WAIT_SWAP);

endmodule
`default_nettype wire

// File: tb/tb_fir_cff_bank.sv
`default_nettype none
// ============================================================================
// Module  : tb_fir_cff_bank
// Brief   : Scoreboard bench for fir_cff_bank with a set-level reference model.
// Rev     : 1.0
// ============================================================================
module tb_fir_cff_bank;

    localparam int ADDR_W   = 3;
    localparam int DATA_W   = 16;
    localparam int NUM_TAPS = 4;
`ifdef FIR_CFF_CHECKSUM_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    localparam int M_IDLE = 0;
    localparam int M_LOAD = 1;
    localparam int M_WAIT = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [ADDR_W-1:0] cff_ptr = '0;
    logic [DATA_W-1:0] cff_out;
    logic              sequencing = 1'b0;
    logic              ld_start = 1'b0;
    logic              ld_vld = 1'b0;
    logic [DATA_W-1:0] ld_data = '0;
    logic              ld_rdy;
    logic              ld_done;
    logic              ld_err;
    logic              active_bank;
    logic              swap_pend;
    logic [DATA_W-1:0] ld_chk = '0;
    logic [DATA_W-1:0] ld_sum;

    always #5 clk = ~clk;

    fir_cff_bank #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .NUM_TAPS(NUM_TAPS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cff_ptr    (cff_ptr),
        .cff_out    (cff_out),
        .sequencing (sequencing),
        .ld_start   (ld_start),
        .ld_vld     (ld_vld),
        .ld_data    (ld_data),
        .ld_rdy     (ld_rdy),
        .ld_done    (ld_done),
        .ld_err     (ld_err),
        .active_bank(active_bank),
        .swap_pend  (swap_pend)
`ifdef FIR_CFF_CHECKSUM_EN
        ,
        .ld_chk     (ld_chk),
        .ld_sum     (ld_sum)
`endif
    );

    typedef struct {
        logic [DATA_W-1:0] cff;
        bit                cff_known;
        bit                active;
        bit                done;
        bit                err;
        bit                pend;
        bit                rdy;
        logic [DATA_W-1:0] sum;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   running = 1'b0;

    // Reference: contents of both banks, which one is served, and load progress.
    logic [DATA_W-1:0] m_set   [2][2**ADDR_W];
    bit                m_known [2][2**ADDR_W];
    bit                m_active;
    int                m_mode;
    int                m_cnt;
    logic [DATA_W-1:0] m_sum;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        if (running && q.size() > 0) begin
            #1;
            e = q.pop_front();
            if (e.cff_known) check("cff_out", 32'(cff_out), 32'(e.cff));
            check("active_bank", 32'(active_bank), 32'(e.active));
            check("ld_done", 32'(ld_done), 32'(e.done));
            check("ld_err", 32'(ld_err), 32'(e.err));
            check("swap_pend", 32'(swap_pend), 32'(e.pend));
            check("ld_rdy", 32'(ld_rdy), 32'(e.rdy));
`ifdef FIR_CFF_CHECKSUM_EN
            check("ld_sum", 32'(ld_sum), 32'(e.sum));
`endif
        end
    end

    // Drive one cycle of inputs and push what the DUT must show after the edge.
    task automatic drive(input logic [ADDR_W-1:0] p, input bit seq, input bit st,
                         input bit vld, input logic [DATA_W-1:0] d,
                         input logic [DATA_W-1:0] chk);
        exp_t e;
        @(negedge clk);
        cff_ptr = p; sequencing = seq; ld_start = st; ld_vld = vld;
        ld_data = d; ld_chk = chk;
        e.done = 1'b0;
        e.err  = 1'b0;
        if (int'(p) < NUM_TAPS) begin
            e.cff       = m_set[m_active][p];
            e.cff_known = m_known[m_active][p];
        end else begin
            e.cff       = '0;
            e.cff_known = 1'b1;
        end
        if (st) m_sum = '0;
        case (m_mode)
            M_IDLE: if (st) begin m_mode = M_LOAD; m_cnt = 0; end
            M_LOAD: begin
                if (st) begin
                    e.err = 1'b1; m_cnt = 0;
                end else if (vld) begin
                    m_set[~m_active][m_cnt[ADDR_W-1:0]]   = d;
                    m_known[~m_active][m_cnt[ADDR_W-1:0]] = 1'b1;
                    m_sum = m_sum + d;
                    m_cnt++;
                    if (m_cnt == NUM_TAPS) begin
                        if (CHK && (m_sum != chk)) begin
                            e.err = 1'b1; m_mode = M_IDLE;
                        end else begin
                            m_mode = M_WAIT;
                        end
                    end
                end
            end
            default: begin
                if (st) begin
                    e.err = 1'b1; m_mode = M_LOAD; m_cnt = 0;
                end else if (!seq) begin
                    m_active = ~m_active; e.done = 1'b1; m_mode = M_IDLE;
                end
            end
        endcase
        e.active = m_active;
        e.pend   = (m_mode == M_WAIT);
        e.rdy    = (m_mode == M_LOAD);
        e.sum    = m_sum;
        q.push_back(e);
    endtask

    function automatic logic [DATA_W-1:0] good_chk(input logic [DATA_W-1:0] d);
        return m_sum + d;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        running = 1'b0;
        rst = 1'b1; ld_start = 1'b0; ld_vld = 1'b0; sequencing = 1'b0;
        #1;
        check("rst cff_out", 32'(cff_out), 32'h0);
        check("rst active_bank", 32'(active_bank), 32'h0);
        check("rst ld_rdy", 32'(ld_rdy), 32'h0);
        check("rst ld_done", 32'(ld_done), 32'h0);
        check("rst ld_err", 32'(ld_err), 32'h0);
        check("rst swap_pend", 32'(swap_pend), 32'h0);
`ifdef FIR_CFF_CHECKSUM_EN
        check("rst ld_sum", 32'(ld_sum), 32'h0);
`endif
        m_active = 1'b0; m_mode = M_IDLE; m_cnt = 0; m_sum = '0;
        @(negedge clk);
        rst = 1'b0;
        running = 1'b1;
    endtask

    task automatic load4(input logic [DATA_W-1:0] w0, w1, w2, w3, input bit seq);
        logic [DATA_W-1:0] w [4];
        w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
        drive(3'd5, seq, 1'b1, 1'b0, '0, '0);
        for (int i = 0; i < 4; i++) drive(3'(i), seq, 1'b0, 1'b1, w[i], good_chk(w[i]));
    endtask

    initial begin
        bit                seq_r;
        logic [DATA_W-1:0] d;
        logic [DATA_W-1:0] c;
        m_known = '{default: '0};
        m_set   = '{default: '0};
        do_reset();

        // Basic load with the filter idle, then read back the last tap.
        load4(16'h0001, 16'h0002, 16'h0003, 16'h7FFF, 1'b0);
        for (int i = 0; i < 3; i++) drive(3'd5, 1'b0, 1'b0, 1'b0, '0, '0);
        drive(3'd3, 1'b0, 1'b0, 1'b0, '0, '0);
        drive(3'd5, 1'b0, 1'b0, 1'b0, '0, '0);

        // Load while sequencing; reads sweep the old set until the swap.
        drive(3'd0, 1'b1, 1'b1, 1'b0, '0, '0);
        for (int i = 0; i < 4; i++)
            drive(3'(i), 1'b1, 1'b0, 1'b1, 16'hA000 + 16'(i), good_chk(16'hA000 + 16'(i)));
        for (int i = 0; i < 20; i++) drive(3'(i % 4), 1'b1, 1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 6; i++) drive(3'(i % 4), 1'b0, 1'b0, 1'b0, '0, '0);

        // Restart after two words, including a word concurrent with ld_start.
        drive(3'd1, 1'b0, 1'b1, 1'b0, '0, '0);
        drive(3'd1, 1'b0, 1'b0, 1'b1, 16'h1111, '0);
        drive(3'd2, 1'b0, 1'b0, 1'b1, 16'h2222, '0);
        drive(3'd2, 1'b0, 1'b1, 1'b1, 16'h9999, '0);
        for (int i = 0; i < 4; i++)
            drive(3'(i), 1'b0, 1'b0, 1'b1, 16'h5550 + 16'(i), good_chk(16'h5550 + 16'(i)));
        for (int i = 0; i < 8; i++) drive(3'(i), 1'b0, 1'b0, 1'b0, '0, '0);

        // Restart while a complete set waits for the swap.
        load4(16'h0BAD, 16'h0BAD, 16'h0BAD, 16'h0BAD, 1'b1);
        drive(3'd0, 1'b1, 1'b1, 1'b0, '0, '0);
        for (int i = 0; i < 4; i++) drive(3'(i), 1'b1, 1'b0, 1'b0, '0, '0);
        load4(16'hC000, 16'hC001, 16'hC002, 16'hC003, 1'b0);
        for (int i = 0; i < 6; i++) drive(3'(i), 1'b0, 1'b0, 1'b0, '0, '0);

`ifdef FIR_CFF_CHECKSUM_EN
        load4(16'h8000, 16'h8000, 16'h0001, 16'h0002, 1'b0);
        for (int i = 0; i < 5; i++) drive(3'(i), 1'b0, 1'b0, 1'b0, '0, '0);
        drive(3'd5, 1'b0, 1'b1, 1'b0, '0, '0);
        drive(3'd0, 1'b0, 1'b0, 1'b1, 16'h8000, '0);
        drive(3'd1, 1'b0, 1'b0, 1'b1, 16'h8000, '0);
        drive(3'd2, 1'b0, 1'b0, 1'b1, 16'h0001, '0);
        drive(3'd3, 1'b0, 1'b0, 1'b1, 16'h0002, 16'h0004);
        for (int i = 0; i < 5; i++) drive(3'(i), 1'b0, 1'b0, 1'b0, '0, '0);
`endif

        // Randomized traffic, with one reset landing mid-stream.
        seq_r = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) seq_r = ~seq_r;
            d = 16'($urandom);
            c = ($urandom_range(0, 3) != 0) ? good_chk(d) : 16'($urandom);
            drive(3'($urandom_range(0, 7)), seq_r, ($urandom_range(0, 39) == 0),
                  ($urandom_range(0, 2) != 0), d, c);
            if (i == 1500) do_reset();
        end
        for (int i = 0; i < 8; i++) drive(3'(i), 1'b0, 1'b0, 1'b0, '0, '0);

        @(negedge clk);
        @(negedge clk);
        check("scoreboard drained", 32'(q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
